// File: rtl/mdu_seq.sv
`default_nettype none
// ============================================================================
// Module  : mdu_seq
// Brief   : Iterative 32-step multiply/divide sequencer owning the HI/LO pair.
// Revision: 1.0 - initial release
// ============================================================================
module mdu_seq #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] opnd1,
    input  logic [DATA_W-1:0] opnd2,
    input  logic              flush,
    input  logic              mf_req,
    output logic              busy,
    output logic              stall_req,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_last = CNT_W'(DATA_W - 1);

    state_t                r_state, w_state_next;
    logic [CNT_W-1:0]      r_cnt;
    logic [2*DATA_W-1:0]   r_acc;   // product, or {remainder, quotient}
    logic [DATA_W-1:0]     r_opb;   // multiplicand or divisor magnitude
    logic                  r_s1, r_s2, r_signed, r_div, r_done;
    logic [DATA_W-1:0]     r_hi, r_lo;

    logic                  w_cmd_md, w_op_signed, w_neg1, w_neg2;
    logic [DATA_W-1:0]     w_mag1, w_mag2;
    logic [DATA_W:0]       w_sum, w_rem_sh;
    logic [DATA_W-1:0]     w_rem_sub;
    logic                  w_ge;
    logic [2*DATA_W-1:0]   w_mul_next, w_div_next, w_prod_fix;
    logic [DATA_W-1:0]     w_quot_fix, w_rem_fix;

    assign w_cmd_md    = start && !flush && !op[2];
    assign w_op_signed = !op[0];
    assign w_neg1      = w_op_signed && opnd1[DATA_W-1];
    assign w_neg2      = w_op_signed && opnd2[DATA_W-1];
    assign w_mag1      = w_neg1 ? -opnd1 : opnd1;
    assign w_mag2      = w_neg2 ? -opnd2 : opnd2;

    // Multiply: accumulate into the upper half, shift multiplier out of the low half.
    assign w_sum      = {1'b0, r_acc[2*DATA_W-1:DATA_W]} + (r_acc[0] ? {1'b0, r_opb} : '0);
    assign w_mul_next = {w_sum, r_acc[DATA_W-1:1]};

    // Divide: shifted remainder needs one extra bit before the compare.
    assign w_rem_sh   = r_acc[2*DATA_W-1:DATA_W-1];
    assign w_ge       = w_rem_sh >= {1'b0, r_opb};
    assign w_rem_sub  = w_rem_sh[DATA_W-1:0] - r_opb;
    assign w_div_next = w_ge ? {w_rem_sub, r_acc[DATA_W-2:0], 1'b1}
                             : {w_rem_sh[DATA_W-1:0], r_acc[DATA_W-2:0], 1'b0};

    assign w_prod_fix = (r_signed && (r_s1 ^ r_s2)) ? -r_acc : r_acc;
    assign w_quot_fix = (r_signed && (r_s1 ^ r_s2)) ? -r_acc[DATA_W-1:0] : r_acc[DATA_W-1:0];
    assign w_rem_fix  = (r_signed && r_s1) ? -r_acc[2*DATA_W-1:DATA_W] : r_acc[2*DATA_W-1:DATA_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_cmd_md) w_state_next = S_CALC;
            S_CALC:  if (flush) w_state_next = S_IDLE;
                     else if (r_cnt == c_last) w_state_next = S_FIX;
            S_FIX:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opb    <= '0;
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_signed <= 1'b0;
            r_div    <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_cmd_md) begin
                        r_cnt    <= '0;
                        r_s1     <= w_neg1;
                        r_s2     <= w_neg2;
                        r_signed <= w_op_signed;
                        r_div    <= op[1];
                        if (op[1]) begin
                            r_acc <= {{DATA_W{1'b0}}, w_mag1};
                            r_opb <= w_mag2;
                        end else begin
                            r_acc <= {{DATA_W{1'b0}}, w_mag2};
                            r_opb <= w_mag1;
                        end
                    end else if (start && !flush && op == 3'd4) begin
                        r_hi <= opnd1;
                    end else if (start && !flush && op == 3'd5) begin
                        r_lo <= opnd1;
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt + 1'b1;
                    r_acc <= r_div ? w_div_next : w_mul_next;
                end
                S_FIX: begin
                    if (!flush) begin
                        r_done <= 1'b1;
                        if (r_div) begin
                            r_hi <= w_rem_fix;
                            r_lo <= w_quot_fix;
                        end else begin
                            r_hi <= w_prod_fix[2*DATA_W-1:DATA_W];
                            r_lo <= w_prod_fix[DATA_W-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign stall_req = busy && (mf_req || start);
    assign done      = r_done;
    assign hi        = r_hi;
    assign lo        = r_lo;

endmodule
`default_nettype wire
